dual_issue_ctrl: RTL and testbench
==================================

// Module: dual_issue_ctrl
// PURPOSE
//  Dual-issue stage between decode and execute, upstream of score_board.
//  - Buffers one decoded instruction pair.
//  - Checks RAW and WAW hazards against the scoreboard's shifting position vectors.
//  - Issues 0, 1 or 2 instructions in order per cycle.
//  - Records each issued writer's result latency back into the scoreboard.
// PARAMETERS
//  POS_W     8   width of SCORE_BOARD_DATA.position; bit k set = result written back in k cycles
//  READY_LSB 1   operand ready when position[POS_W-1:READY_LSB]==0 (bypass covers bits below)
//  CNT_W     32  width of stall_count
// PORTS
//  clk            in   1            clock
//  rst            in   1            asynchronous reset, active-high
//  flush          in   1            branch/exception flush; clears buffer and issue register
//  in_valid       in   1            decode offers a pair
//  in_slot_valid  in   2            per-slot valid; legal values 01 and 11 only (slot0 is older)
//  in_inst        in   2xISSUE_INST decoded pair
//  in_ready       out  1            pair accepted at this edge when in_valid&in_ready
//  sb_read_addr   out  4xREG_ADDR   {b1.rt, b1.rs, b0.rt, b0.rs}
//  sb_data        in   4xSCORE_BOARD_DATA  same-cycle combinational read result
//  sb_write_ena   out  2            scoreboard write strobes
//  sb_write_addr  out  2xREG_ADDR   issued destination registers
//  sb_write_data  out  2xSCORE_BOARD_DATA  position = 1<<lat
//  ex_ready       in   1            execute can take a new issue word
//  ex_valid       out  2            registered per-slot valid to execute
//  ex_inst        out  2xISSUE_INST registered issued instructions
//  stall_count    out  CNT_W        cycles with b0 valid but nothing issued
// BEHAVIOUR
//  - Reset (async): b0/b1 invalid, ex_valid=0, ex_inst=0, stall_count=0.
//    All combinational outputs are then 0; in_ready=1.
//  - Buffer: b0 = older slot, b1 = younger slot, each with a valid bit.
//  - Operand readiness: unused operands and r0 are always ready.
//    Otherwise ready iff (sb_data.position >> READY_LSB)==0.
//  - can0 = b0 valid & ex_ready & !flush & both operands ready
//    & WAW ok (rd unused, or rd==0, or sb position for rd < (1<<lat)).
//  - WAW check needs position of rd: add a 5th internal lookup only if rd not in
//    {rs,rt}; otherwise reuse. Preferred: ISSUE_INST carries rd == rs/rt match flags
//    from decode; the design shall be correct for any rd.
//  - can1 = can0 & b1 valid & b1 operands ready & b1 WAW ok
//    & b1 reads no register written by b0 (intra-pair RAW).
//    b1 never issues without b0.
//  - Issue (clock edge with can0): ex_valid <= {can1,1}; ex_inst <= {b1,b0}.
//    sb_write_ena[i] = issued_i & rd_used & rd!=0.
//    If both issued with the same rd, sb_write_ena[0] is forced 0 (younger wins).
//  - !ex_ready: ex_valid/ex_inst hold; nothing issues.
//  - ex_ready & !can0: ex_valid <= 0.
//  - Buffer update:
//    - both issued or buffer empty: load {in_inst} if in_valid.
//    - only b0 issued: b1 -> b0, b1 invalid, in_ready=0 this cycle.
//    - none issued: hold.
//  - in_ready = !flush & (buffer empty | (can0 & (can1 | !b1 valid))).
//  - Scoreboard write visibility is next cycle. A b1 that depends on an issuing b0
//    is resolved by the intra-pair check, never by sb_data.
//  - flush: highest priority. Next edge b0, b1 and ex_valid cleared.
//    sb_write_ena=0 this cycle; in_valid ignored.
//  - stall_count increments when b0 valid & !can0 & !flush; saturates at all-ones.
//  - lat is 1..POS_W-1. lat=0 or lat>=POS_W is illegal (assertion).
//  - in_slot_valid=10 is illegal (assertion).
// STRUCTURE
//  - Package (defines.svh): ISSUE_INST struct {pc, rs, rt, rd, rs_used, rt_used,
//    rd_used, lat[$clog2(POS_W)-1:0], payload}; extend SCORE_BOARD_DATA with
//    POS_W-based position.
//  - Sub-module issue_hazard_chk (pure comb): one slot's operand data
//    -> ready/waw_ok. Instantiated twice.
//  - Top holds buffer, issue register, counter.
// TESTING
//  1. Independent pair, add r3<-r1,r2 (lat1) and add r6<-r4,r5 (lat1), scoreboard
//     empty -> ex_valid=11 next edge; sb_write_ena=11, addr {6,3}, data {1<<1,1<<1}.
//  2. Intra-pair RAW, b0 writes r3, b1 reads r3 -> cycle1 ex_valid=01, in_ready=0;
//     b1 compacts to b0 and issues next cycle (position(r3)=1, ready).
//  3. Load r5 lat3 issued, next pair reads r5 -> stalls 2 cycles (position 100b, 010b);
//     issues when position=001b; stall_count=2.
//  4. Same-rd pair, both write r7 -> ex_valid=11, sb_write_ena=10, addr[1]=7.
//  5. ex_ready=0 for 3 cycles with pair buffered -> ex outputs held, in_ready=0,
//     no sb writes; issue resumes at first ex_ready=1.
//  6. flush with full buffer and ex_valid=11 -> next edge all invalid, sb_write_ena=0;
//     assert rst mid-stall -> stall_count=0 immediately (async).

Source files
------------

// File: rtl/dual_issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dual_issue_ctrl_pkg                                         |
// | Brief  : Shared types and constants for the dual-issue stage.        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package dual_issue_ctrl_pkg;

  localparam int POS_W         = 8;
  localparam int DEF_READY_LSB = 1;
  localparam int DEF_CNT_W     = 32;
  localparam int REG_AW        = 5;
  localparam int NUM_REGS      = 1 << REG_AW;
  localparam int LAT_W         = $clog2(POS_W);
  localparam int PAYLOAD_W     = 16;

  typedef logic [REG_AW-1:0] REG_ADDR;

  typedef struct packed {
    logic [31:0]          pc;
    REG_ADDR              rs;
    REG_ADDR              rt;
    REG_ADDR              rd;
    logic                 rs_used;
    logic                 rt_used;
    logic                 rd_used;
    logic [LAT_W-1:0]     lat;
    logic [PAYLOAD_W-1:0] payload;
  } ISSUE_INST;

  // position bit k set = result written back in k cycles
  typedef struct packed {
    logic [POS_W-1:0] position;
  } SCORE_BOARD_DATA;

  // One-hot position word for a writer of latency lat.
  function automatic logic [POS_W-1:0] lat_mask(input logic [LAT_W-1:0] lat);
    logic [POS_W-1:0] one;
    one = POS_W'(1);
    return one << lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dual_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dual_issue_ctrl_if                                          |
// | Brief  : Decode, scoreboard and execute bundle of the issue stage.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface dual_issue_ctrl_if;
  import dual_issue_ctrl_pkg::*;

  logic                       in_valid;
  logic [1:0]                 in_slot_valid;
  ISSUE_INST [1:0]            in_inst;
  logic                       in_ready;

  REG_ADDR [3:0]              sb_read_addr;
  SCORE_BOARD_DATA [3:0]      sb_data;
  logic [1:0]                 sb_write_ena;
  REG_ADDR [1:0]              sb_write_addr;
  SCORE_BOARD_DATA [1:0]      sb_write_data;

  logic                       ex_ready;
  logic [1:0]                 ex_valid;
  ISSUE_INST [1:0]            ex_inst;

  // Issue stage side
  modport slave (
    input  in_valid, in_slot_valid, in_inst, sb_data, ex_ready,
    output in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_write_data,
           ex_valid, ex_inst
  );

  // Surrounding pipeline side (decode, scoreboard, execute)
  modport master (
    output in_valid, in_slot_valid, in_inst, sb_data, ex_ready,
    input  in_ready, sb_read_addr, sb_write_ena, sb_write_addr, sb_write_data,
           ex_valid, ex_inst
  );

endinterface
`default_nettype wire

// File: rtl/dual_issue_ctrl_issue_hazard_chk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : issue_hazard_chk                                            |
// | Brief  : Per-slot RAW readiness and WAW ordering check (pure comb).  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module issue_hazard_chk
  import dual_issue_ctrl_pkg::*;
#(
  parameter int READY_LSB = DEF_READY_LSB
) (
  input  REG_ADDR          rs,
  input  REG_ADDR          rt,
  input  REG_ADDR          rd,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             rd_used,
  input  logic [LAT_W-1:0] lat,
  input  SCORE_BOARD_DATA  rs_data,
  input  SCORE_BOARD_DATA  rt_data,
  input  logic [POS_W-1:0] rd_shadow_pos,
  output logic             ready,
  output logic             waw_ok
);

  logic             w_rs_ready;
  logic             w_rt_ready;
  logic [POS_W-1:0] w_rd_pos;

  // Operands are ready when nothing is outstanding beyond the bypass window;
  // the destination position reuses an operand lookup when it names the same register.
  always_comb begin
    w_rs_ready = !rs_used || (rs == '0) || ((rs_data.position >> READY_LSB) == '0);
    w_rt_ready = !rt_used || (rt == '0) || ((rt_data.position >> READY_LSB) == '0);
    if (rs_used && (rs == rd))      w_rd_pos = rs_data.position;
    else if (rt_used && (rt == rd)) w_rd_pos = rt_data.position;
    else                            w_rd_pos = rd_shadow_pos;
    ready  = w_rs_ready && w_rt_ready;
    waw_ok = !rd_used || (rd == '0) || (w_rd_pos < lat_mask(lat));
  end

endmodule
`default_nettype wire

// File: rtl/dual_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : dual_issue_ctrl                                             |
// | Brief  : In-order dual-issue stage with scoreboard hazard checking.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int READY_LSB = DEF_READY_LSB,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  dual_issue_ctrl_if.slave  bus,
  output logic [CNT_W-1:0]  stall_count
);

  ISSUE_INST        r_b0;
  ISSUE_INST        r_b1;
  logic             r_b0_valid;
  logic             r_b1_valid;
  logic [1:0]       r_ex_valid;
  ISSUE_INST [1:0]  r_ex_inst;
  logic [CNT_W-1:0] r_stall_count;
  // Pending-writeback position of each register as written by this stage,
  // used for the destination lookup that has no scoreboard read port.
  logic [POS_W-1:0] r_shadow [NUM_REGS];

  logic       w_ready0, w_waw0, w_ready1, w_waw1;
  logic       w_b1_raw;
  logic       w_can0, w_can1;
  logic       w_all_issued;
  logic       w_in_ready;
  logic       w_load;
  logic [1:0] w_ena;

  assign bus.sb_read_addr = {r_b1.rt, r_b1.rs, r_b0.rt, r_b0.rs};
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_inst      = r_ex_inst;
  assign bus.in_ready     = w_in_ready;
  assign stall_count      = r_stall_count;

  issue_hazard_chk #(.READY_LSB(READY_LSB)) u_chk0 (
    .rs(r_b0.rs), .rt(r_b0.rt), .rd(r_b0.rd),
    .rs_used(r_b0.rs_used), .rt_used(r_b0.rt_used), .rd_used(r_b0.rd_used),
    .lat(r_b0.lat), .rs_data(bus.sb_data[0]), .rt_data(bus.sb_data[1]),
    .rd_shadow_pos(r_shadow[r_b0.rd]), .ready(w_ready0), .waw_ok(w_waw0)
  );

  issue_hazard_chk #(.READY_LSB(READY_LSB)) u_chk1 (
    .rs(r_b1.rs), .rt(r_b1.rt), .rd(r_b1.rd),
    .rs_used(r_b1.rs_used), .rt_used(r_b1.rt_used), .rd_used(r_b1.rd_used),
    .lat(r_b1.lat), .rs_data(bus.sb_data[2]), .rt_data(bus.sb_data[3]),
    .rd_shadow_pos(r_shadow[r_b1.rd]), .ready(w_ready1), .waw_ok(w_waw1)
  );

  // Issue decision: b1 may only ride along with b0 and never consumes b0's result.
  always_comb begin
    w_b1_raw     = r_b0.rd_used && (r_b0.rd != '0) &&
                   ((r_b1.rs_used && (r_b1.rs == r_b0.rd)) ||
                    (r_b1.rt_used && (r_b1.rt == r_b0.rd)));
    w_can0       = r_b0_valid && bus.ex_ready && !flush && w_ready0 && w_waw0;
    w_can1       = w_can0 && r_b1_valid && w_ready1 && w_waw1 && !w_b1_raw;
    w_all_issued = w_can0 && (w_can1 || !r_b1_valid);
    w_in_ready   = !flush && (!r_b0_valid || w_all_issued);
    w_load       = bus.in_valid && w_in_ready;
    w_ena[1]     = w_can1 && r_b1.rd_used && (r_b1.rd != '0);
    // Same destination in one issue word: the younger write is the one that counts.
    w_ena[0]     = w_can0 && r_b0.rd_used && (r_b0.rd != '0) &&
                   !(w_ena[1] && (r_b1.rd == r_b0.rd));
  end

  // Scoreboard write port; address and data read as zero when not strobed.
  always_comb begin
    bus.sb_write_ena  = w_ena;
    bus.sb_write_addr = '0;
    bus.sb_write_data = '0;
    if (w_ena[0]) begin
      bus.sb_write_addr[0]          = r_b0.rd;
      bus.sb_write_data[0].position = lat_mask(r_b0.lat);
    end
    if (w_ena[1]) begin
      bus.sb_write_addr[1]          = r_b1.rd;
      bus.sb_write_data[1].position = lat_mask(r_b1.lat);
    end
  end

  // Instruction-pair buffer: load when drained, compact b1 into b0 on a single issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b0       <= '0;
      r_b1       <= '0;
      r_b0_valid <= 1'b0;
      r_b1_valid <= 1'b0;
    end else if (flush) begin
      r_b0_valid <= 1'b0;
      r_b1_valid <= 1'b0;
    end else if (w_load) begin
      r_b0       <= bus.in_inst[0];
      r_b1       <= bus.in_inst[1];
      r_b0_valid <= 1'b1;
      r_b1_valid <= bus.in_slot_valid[1];
    end else if (w_all_issued) begin
      r_b0_valid <= 1'b0;
      r_b1_valid <= 1'b0;
    end else if (w_can0) begin
      r_b0       <= r_b1;
      r_b0_valid <= 1'b1;
      r_b1_valid <= 1'b0;
    end
  end

  // Issue register toward execute; holds while execute is not ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid <= '0;
      r_ex_inst  <= '0;
    end else if (flush) begin
      r_ex_valid <= '0;
    end else if (bus.ex_ready) begin
      r_ex_valid <= w_can0 ? {w_can1, 1'b1} : 2'b00;
      if (w_can0) r_ex_inst <= {r_b1, r_b0};
    end
  end

  // Saturating count of cycles where the oldest instruction is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (r_b0_valid && !w_can0 && !flush && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_shadow
    // Mirrors the scoreboard: a write becomes visible already shifted once, then shifts each cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_shadow[g] <= '0;
      end else if (w_ena[1] && (r_b1.rd == REG_ADDR'(g))) begin
        r_shadow[g] <= lat_mask(r_b1.lat) >> 1;
      end else if (w_ena[0] && (r_b0.rd == REG_ADDR'(g))) begin
        r_shadow[g] <= lat_mask(r_b0.lat) >> 1;
      end else begin
        r_shadow[g] <= r_shadow[g] >> 1;
      end
    end
  end

  a_slot_valid_legal : assert property (@(posedge clk) disable iff (rst)
    bus.in_valid |-> (bus.in_slot_valid != 2'b10));

  a_lat0_legal : assert property (@(posedge clk) disable iff (rst)
    (w_load && bus.in_inst[0].rd_used) |-> (bus.in_inst[0].lat != '0));

  a_lat1_legal : assert property (@(posedge clk) disable iff (rst)
    (w_load && bus.in_slot_valid[1] && bus.in_inst[1].rd_used) |-> (bus.in_inst[1].lat != '0));

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_dual_issue_ctrl                                          |
// | Brief  : Directed and random checks against a queue-based model.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_dual_issue_ctrl;
  import dual_issue_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [DEF_CNT_W-1:0] stall_count;

  dual_issue_ctrl_if bus ();

  dual_issue_ctrl #(.READY_LSB(DEF_READY_LSB), .CNT_W(DEF_CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference state: absolute writeback cycle per register, queue of buffered instructions.
  int                   now;
  int                   wb [NUM_REGS];
  ISSUE_INST            bq [$];
  logic [1:0]           m_ex_valid;
  ISSUE_INST            m_ex_inst [2];
  logic [DEF_CNT_W-1:0] m_stall;
  int                   n_assert = 0;
  int                   n_fail   = 0;

  logic       obs_in_ready;
  logic [1:0] obs_ena;
  REG_ADDR    obs_addr [2];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [POS_W-1:0] sb_pos(input REG_ADDR r);
    int d;
    logic [POS_W-1:0] one;
    one = POS_W'(1);
    d = wb[r] - now;
    if (d >= 0 && d < POS_W) return one << d;
    return '0;
  endfunction

  function automatic bit op_ready(input bit used, input REG_ADDR r);
    return !used || (r == 0) || ((wb[r] - now) < DEF_READY_LSB);
  endfunction

  function automatic bit waw_fine(input ISSUE_INST i);
    return !i.rd_used || (i.rd == 0) || ((wb[i.rd] - now) < int'(i.lat));
  endfunction

  function automatic bit writes(input ISSUE_INST i);
    return i.rd_used && (i.rd != 0);
  endfunction

  function automatic bit reads(input ISSUE_INST i, input REG_ADDR r);
    return (i.rs_used && i.rs == r) || (i.rt_used && i.rt == r);
  endfunction

  function automatic ISSUE_INST mk(input int rd, input int rs, input int rt,
                                   input bit rdu, input bit rsu, input bit rtu, input int lat);
    ISSUE_INST i;
    i.pc      = $urandom;
    i.rs      = REG_ADDR'(rs);
    i.rt      = REG_ADDR'(rt);
    i.rd      = REG_ADDR'(rd);
    i.rs_used = rsu;
    i.rt_used = rtu;
    i.rd_used = rdu;
    i.lat     = LAT_W'(lat);
    i.payload = PAYLOAD_W'($urandom);
    return i;
  endfunction

  task automatic model_reset();
    bq.delete();
    m_ex_valid = '0;
    m_ex_inst[0] = '0;
    m_ex_inst[1] = '0;
    m_stall = '0;
    for (int r = 0; r < NUM_REGS; r++) wb[r] = -1000;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge, check registers.
  task automatic step(input bit iv, input logic [1:0] sv, input ISSUE_INST i0, input ISSUE_INST i1,
                      input bit exr, input bit fl);
    int sz;
    bit c0, c1, e0, e1, e_rdy;
    ISSUE_INST b0, b1;
    logic [POS_W-1:0] one;
    one = POS_W'(1);
    @(negedge clk);
    bus.in_valid      = iv;
    bus.in_slot_valid = sv;
    bus.in_inst[0]    = i0;
    bus.in_inst[1]    = i1;
    bus.ex_ready      = exr;
    flush             = fl;
    for (int k = 0; k < 4; k++) bus.sb_data[k].position = sb_pos(bus.sb_read_addr[k]);
    #1;
    sz = bq.size();
    b0 = (sz > 0) ? bq[0] : '0;
    b1 = (sz > 1) ? bq[1] : '0;
    c0 = (sz > 0) && exr && !fl && op_ready(b0.rs_used, b0.rs) && op_ready(b0.rt_used, b0.rt) && waw_fine(b0);
    c1 = c0 && (sz > 1) && op_ready(b1.rs_used, b1.rs) && op_ready(b1.rt_used, b1.rt) && waw_fine(b1)
         && !(writes(b0) && reads(b1, b0.rd));
    e_rdy = !fl && ((sz == 0) || (c0 && (c1 || sz == 1)));
    e1 = c1 && writes(b1);
    e0 = c0 && writes(b0) && !(e1 && b1.rd == b0.rd);
    obs_in_ready = bus.in_ready;
    obs_ena      = bus.sb_write_ena;
    obs_addr[0]  = bus.sb_write_addr[0];
    obs_addr[1]  = bus.sb_write_addr[1];
    chk("in_ready", bus.in_ready, e_rdy);
    chk("sb_write_ena", bus.sb_write_ena, {e1, e0});
    if (e0) begin
      chk("sb_write_addr0", bus.sb_write_addr[0], b0.rd);
      chk("sb_write_data0", bus.sb_write_data[0].position, one << b0.lat);
    end
    if (e1) begin
      chk("sb_write_addr1", bus.sb_write_addr[1], b1.rd);
      chk("sb_write_data1", bus.sb_write_data[1].position, one << b1.lat);
    end
    @(posedge clk);
    if (e0) wb[b0.rd] = now + int'(b0.lat);
    if (e1) wb[b1.rd] = now + int'(b1.lat);
    if ((sz > 0) && !c0 && !fl && (m_stall != '1)) m_stall++;
    if (fl) begin
      bq.delete();
      m_ex_valid = '0;
    end else begin
      if (exr) begin
        m_ex_valid = c0 ? {c1, 1'b1} : 2'b00;
        if (c0) begin
          m_ex_inst[0] = b0;
          m_ex_inst[1] = b1;
        end
      end
      if (c1) begin
        void'(bq.pop_front());
        void'(bq.pop_front());
      end else if (c0) begin
        void'(bq.pop_front());
      end
      if (iv && e_rdy) begin
        bq.push_back(i0);
        if (sv[1]) bq.push_back(i1);
      end
    end
    now++;
    #1;
    chk("ex_valid", bus.ex_valid, m_ex_valid);
    if (m_ex_valid[0]) chk("ex_inst0", bus.ex_inst[0], m_ex_inst[0]);
    if (m_ex_valid[1]) chk("ex_inst1", bus.ex_inst[1], m_ex_inst[1]);
    chk("stall_count", stall_count, m_stall);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b01, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    ISSUE_INST p0, p1, q0, q1;
    logic [DEF_CNT_W-1:0] s0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_slot_valid = 2'b01;
    bus.in_inst = '0;
    bus.ex_ready = 1'b0;
    bus.sb_data = '0;
    now = 0;
    model_reset();
    #12;
    chk("rst_ex_valid", bus.ex_valid, 2'b00);
    chk("rst_ex_inst", bus.ex_inst, '0);
    chk("rst_stall", stall_count, '0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_sb_ena", bus.sb_write_ena, 2'b00);
    chk("rst_sb_addr", bus.sb_write_addr, '0);
    chk("rst_sb_data", bus.sb_write_data, '0);
    chk("rst_sb_raddr", bus.sb_read_addr, '0);
    @(negedge clk);
    rst = 1'b0;

    // 1: independent pair
    p0 = mk(3, 1, 2, 1, 1, 1, 1);
    p1 = mk(6, 4, 5, 1, 1, 1, 1);
    step(1'b1, 2'b11, p0, p1, 1'b1, 1'b0);
    step(1'b0, 2'b01, '0, '0, 1'b1, 1'b0);
    chk("t1_ena", obs_ena, 2'b11);
    chk("t1_addr1", obs_addr[1], 5'd6);
    chk("t1_addr0", obs_addr[0], 5'd3);
    chk("t1_ex_valid", bus.ex_valid, 2'b11);
    idle(8);

    // 2: intra-pair RAW compacts b1
    p0 = mk(3, 1, 2, 1, 1, 1, 1);
    p1 = mk(9, 3, 4, 1, 1, 1, 1);
    step(1'b1, 2'b11, p0, p1, 1'b1, 1'b0);
    step(1'b1, 2'b11, p0, p1, 1'b1, 1'b0);
    chk("t2_in_ready", obs_in_ready, 1'b0);
    chk("t2_ex_valid_a", bus.ex_valid, 2'b01);
    step(1'b0, 2'b01, '0, '0, 1'b1, 1'b0);
    chk("t2_ex_valid_b", bus.ex_valid, 2'b01);
    chk("t2_ex_rd", bus.ex_inst[0].rd, 5'd9);
    idle(8);

    // 3: long-latency producer stalls the consumer pair
    s0 = stall_count;
    p0 = mk(5, 0, 0, 1, 0, 0, 3);
    step(1'b1, 2'b01, p0, '0, 1'b1, 1'b0);
    q0 = mk(10, 5, 1, 1, 1, 1, 1);
    q1 = mk(11, 2, 4, 1, 1, 1, 1);
    step(1'b1, 2'b11, q0, q1, 1'b1, 1'b0);
    idle(2);
    chk("t3_stalled", bus.ex_valid, 2'b00);
    idle(1);
    chk("t3_issued", bus.ex_valid, 2'b11);
    chk("t3_stall_count", stall_count - s0, 2);
    idle(8);

    // 4: both write r7, younger wins
    p0 = mk(7, 1, 0, 1, 1, 0, 2);
    p1 = mk(7, 2, 0, 1, 1, 0, 1);
    step(1'b1, 2'b11, p0, p1, 1'b1, 1'b0);
    step(1'b0, 2'b01, '0, '0, 1'b1, 1'b0);
    chk("t4_ena", obs_ena, 2'b10);
    chk("t4_addr1", obs_addr[1], 5'd7);
    chk("t4_ex_valid", bus.ex_valid, 2'b11);
    idle(8);

    // 5: execute back-pressure
    p0 = mk(12, 1, 2, 1, 1, 1, 1);
    p1 = mk(13, 3, 4, 1, 1, 1, 1);
    step(1'b1, 2'b11, p0, p1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 2'b11, p0, p1, 1'b0, 1'b0);
      chk("t5_in_ready", obs_in_ready, 1'b0);
      chk("t5_ena", obs_ena, 2'b00);
    end
    step(1'b0, 2'b01, '0, '0, 1'b1, 1'b0);
    chk("t5_resume", bus.ex_valid, 2'b11);
    idle(8);

    // 6: flush with full buffer and full issue word, then async reset mid-stall
    step(1'b1, 2'b11, mk(14, 1, 2, 1, 1, 1, 1), mk(15, 3, 4, 1, 1, 1, 1), 1'b1, 1'b0);
    step(1'b1, 2'b11, mk(16, 1, 2, 1, 1, 1, 1), mk(17, 3, 4, 1, 1, 1, 1), 1'b1, 1'b0);
    chk("t6_ex_full", bus.ex_valid, 2'b11);
    step(1'b1, 2'b11, mk(18, 1, 2, 1, 1, 1, 1), mk(19, 3, 4, 1, 1, 1, 1), 1'b1, 1'b1);
    chk("t6_flush_ena", obs_ena, 2'b00);
    chk("t6_flush_ex", bus.ex_valid, 2'b00);
    idle(1);
    chk("t6_empty", obs_in_ready, 1'b1);
    idle(8);
    step(1'b1, 2'b01, mk(5, 0, 0, 1, 0, 0, 7), '0, 1'b1, 1'b0);
    step(1'b1, 2'b11, mk(20, 5, 0, 1, 1, 0, 1), mk(21, 1, 0, 1, 1, 0, 1), 1'b1, 1'b0);
    idle(2);
    chk("t6_stalling", stall_count != '0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_stall", stall_count, '0);
    chk("t6_async_ex", bus.ex_valid, 2'b00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 500; n++) begin
      p0 = mk($urandom % 8, $urandom % 8, $urandom % 8, $urandom % 2, $urandom % 2, $urandom % 2,
              $urandom_range(1, 7));
      p1 = mk($urandom % 8, $urandom % 8, $urandom % 8, $urandom % 2, $urandom % 2, $urandom % 2,
              $urandom_range(1, 7));
      step($urandom % 2, ($urandom % 2) ? 2'b11 : 2'b01, p0, p1,
           ($urandom % 4) != 0, ($urandom % 25) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
